// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 responder that emulates the accelerometer register interface, so the
// spi_control master can run in simulation or board loopback without the real G-sensor.
module gsensor_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic        int1,
    output logic        reg_wr_en,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RD, S_WR} state_t;

    logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, sdi_sync, sync_vld;
    logic csn_q, sclk_q, armed;
    logic csn_s, sclk_s, sdi_s;
    logic csn_fall, csn_rise, sclk_rise, sclk_fall;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_next;
    logic [7:0]  tx_shift;
    logic        mb;
    logic [5:0]  addr, addr_next;
    logic        data_read;

    logic [7:0]  bw_rate, power_ctl, int_enable, int_map, data_format;
    logic        data_ready;
    logic [15:0] hold_x, hold_y, hold_z;
    logic [15:0] data_x, data_y, data_z;

    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    // After a reset the chain is forced high; a fall only counts once a genuine
    // high level has propagated, so a transaction cut by reset is ignored to its end.
    assign csn_fall  = armed & csn_q & ~csn_s;
    assign csn_rise  = ~csn_q & csn_s;
    assign sclk_rise = ~sclk_q & sclk_s & ~csn_s;
    assign sclk_fall = sclk_q & ~sclk_s & ~csn_s;
    assign busy      = ~csn_s;

    assign rx_next   = {rx_shift, sdi_s};
    assign addr_next = mb ? addr + 6'd1 : addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            csn_sync  <= '1;
            sclk_sync <= '1;
            sdi_sync  <= '0;
            sync_vld  <= '0;
            csn_q     <= 1'b1;
            sclk_q    <= 1'b1;
            armed     <= 1'b0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            csn_q     <= csn_s;
            sclk_q    <= sclk_s;
            if (sync_vld[SYNC_STAGES-1] && csn_s)
                armed <= 1'b1;
        end
    end

    // NOTE: the default arm keeps this mux fully specified, so no latch is inferred.
    function automatic logic [7:0] reg_read(input logic [5:0] a);
        case (a)
            6'h00:   return DEVID;
            6'h2C:   return bw_rate;
            6'h2D:   return power_ctl;
            6'h2E:   return int_enable;
            6'h2F:   return int_map;
            6'h30:   return {data_ready, 7'b0};
            6'h31:   return data_format;
            6'h32:   return data_x[7:0];
            6'h33:   return data_x[15:8];
            6'h34:   return data_y[7:0];
            6'h35:   return data_y[15:8];
            6'h36:   return data_z[7:0];
            6'h37:   return data_z[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic is_rw(input logic [5:0] a);
        return (a >= 6'h2C && a <= 6'h2F) || a == 6'h31;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            mb          <= 1'b0;
            addr        <= '0;
            data_read   <= 1'b0;
            spi_sdo     <= 1'b0;
            spi_sdo_oe  <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            int1        <= 1'b0;
            bw_rate     <= BW_RATE_RST;
            power_ctl   <= '0;
            int_enable  <= '0;
            int_map     <= '0;
            data_format <= '0;
            data_ready  <= 1'b0;
            // NOTE: the sample registers are a handful of flops, not a RAM, so they
            // are reset with everything else and read back as zero before any sample.
            hold_x      <= '0;
            hold_y      <= '0;
            hold_z      <= '0;
            data_x      <= '0;
            data_y      <= '0;
            data_z      <= '0;
        end else begin
            // NOTE: all state here uses <=, so later assignments in this block
            // (csn rise, sample set) override earlier ones in the same clk.
            reg_wr_en <= 1'b0;
            int1      <= data_ready & int_enable[7] & ~int_map[7];

            if (sample_valid) begin
                hold_x <= sample_x;
                hold_y <= sample_y;
                hold_z <= sample_z;
            end

            case (state)
                S_IDLE: if (csn_fall) begin
                    state      <= S_CMD;
                    bit_cnt    <= '0;
                    spi_sdo_oe <= 1'b1;
                    spi_sdo    <= 1'b0;
                    data_x     <= hold_x;
                    data_y     <= hold_y;
                    data_z     <= hold_z;
                end
                S_CMD: if (sclk_rise) begin
                    rx_shift <= rx_next[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        mb   <= rx_next[6];
                        addr <= rx_next[5:0];
                        if (rx_next[7]) begin
                            state    <= S_RD;
                            tx_shift <= reg_read(rx_next[5:0]);
                        end else begin
                            state <= S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (sclk_fall) begin
                        spi_sdo  <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (addr >= 6'h32 && addr <= 6'h37)
                                data_read <= 1'b1;
                            addr     <= addr_next;
                            tx_shift <= reg_read(addr_next);
                        end
                    end
                end
                S_WR: if (sclk_rise) begin
                    rx_shift <= rx_next[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (is_rw(addr)) begin
                            reg_wr_en   <= 1'b1;
                            reg_wr_addr <= addr;
                            reg_wr_data <= rx_next;
                            case (addr)
                                6'h2C:   bw_rate     <= rx_next;
                                6'h2D:   power_ctl   <= rx_next;
                                6'h2E:   int_enable  <= rx_next;
                                6'h2F:   int_map     <= rx_next;
                                6'h31:   data_format <= rx_next;
                                default: ;
                            endcase
                        end
                        addr <= addr_next;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (csn_rise) begin
                state      <= S_IDLE;
                spi_sdo_oe <= 1'b0;
                spi_sdo    <= 1'b0;
                data_read  <= 1'b0;
                if (data_read)
                    data_ready <= 1'b0;
            end
            // A new sample in the clearing clk keeps DATA_READY set.
            if (sample_valid)
                data_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Directed bench for gsensor_spi_responder: a mode-3 SPI master task set, a table of
// single-transaction vectors, and hand-written sequences for the multi-cycle corners.
module tb_gsensor_spi_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_csn = 1'b1;
    logic        spi_sclk = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo, spi_sdo_oe;
    logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
    logic        sample_valid = 1'b0;
    logic        int1, reg_wr_en, busy;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;

    gsensor_spi_responder dut (
        .clk          (clk),
        .reset        (reset),
        .spi_csn      (spi_csn),
        .spi_sclk     (spi_sclk),
        .spi_sdi      (spi_sdi),
        .spi_sdo      (spi_sdo),
        .spi_sdo_oe   (spi_sdo_oe),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .sample_valid (sample_valid),
        .int1         (int1),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Write-port monitor: counts pulses, so a stretched pulse shows up as extra writes.
    int          wr_cnt = 0;
    logic [5:0]  last_addr = '0;
    logic [7:0]  last_data = '0;
    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    localparam int HALF = 8;  // clk cycles per SCLK half period

    task automatic spi_begin();
        @(negedge clk) spi_csn = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_sclk = 1'b0;
            spi_sdi  = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], spi_sdo};
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic spi_end();
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input int nbytes, input logic [47:0] wdata,
                            output logic [47:0] rd);
        logic [7:0] b;
        rd = '0;
        spi_begin();
        spi_byte(cmd, 8, b);
        for (int j = 0; j < nbytes; j++) begin
            spi_byte(wdata[8*j +: 8], 8, b);
            rd[8*j +: 8] = b;
        end
        spi_end();
    endtask

    task automatic strobe_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        sample_x = x; sample_y = y; sample_z = z;
        sample_valid = 1'b1;
        @(negedge clk) sample_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        int          nbytes;
        logic [47:0] wdata;     // byte j at [8j +: 8]
        logic [47:0] exp_rd;    // byte j at [8j +: 8]
        bit          chk_rd;
        int          exp_wr;
        logic [5:0]  wr_addr;
        logic [7:0]  wr_data;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [7:0] cmd, input int nbytes,
                                input logic [47:0] wdata, input logic [47:0] exp_rd,
                                input bit chk_rd, input int exp_wr,
                                input logic [5:0] wa, input logic [7:0] wd);
        vec_t v;
        v.name = name; v.cmd = cmd; v.nbytes = nbytes; v.wdata = wdata;
        v.exp_rd = exp_rd; v.chk_rd = chk_rd; v.exp_wr = exp_wr;
        v.wr_addr = wa; v.wr_data = wd;
        return v;
    endfunction

    localparam int NV = 14;
    vec_t vecs[NV];

    initial begin
        logic [47:0] rd;
        logic [7:0]  b;
        int          wr0;

        vecs[0]  = mk("rd devid",       8'h80, 1, 48'h0,    48'hE5,   1, 0, 6'h00, 8'h00);
        vecs[1]  = mk("wr power_ctl",   8'h2D, 1, 48'h08,   48'h0,    0, 1, 6'h2D, 8'h08);
        vecs[2]  = mk("rd power_ctl",   8'hAD, 1, 48'h0,    48'h08,   1, 0, 6'h00, 8'h00);
        vecs[3]  = mk("rd bw_rate rst", 8'hAC, 1, 48'h0,    48'h0A,   1, 0, 6'h00, 8'h00);
        vecs[4]  = mk("wr devid ro",    8'h00, 1, 48'h55,   48'h0,    0, 0, 6'h00, 8'h00);
        vecs[5]  = mk("rd devid again", 8'h80, 1, 48'h0,    48'hE5,   1, 0, 6'h00, 8'h00);
        vecs[6]  = mk("wr int_enable",  8'h2E, 1, 48'h80,   48'h0,    0, 1, 6'h2E, 8'h80);
        vecs[7]  = mk("wr int_map",     8'h2F, 1, 48'h00,   48'h0,    0, 1, 6'h2F, 8'h00);
        vecs[8]  = mk("burst wrap 3f",  8'hFF, 2, 48'h0,    48'hE500, 1, 0, 6'h00, 8'h00);
        vecs[9]  = mk("rd int_source",  8'hB0, 1, 48'h0,    48'h00,   1, 0, 6'h00, 8'h00);
        vecs[10] = mk("mb wr 2c",       8'h6C, 2, 48'h081B, 48'h0,    0, 2, 6'h2D, 8'h08);
        vecs[11] = mk("mb rd 2c",       8'hEC, 2, 48'h0,    48'h081B, 1, 0, 6'h00, 8'h00);
        vecs[12] = mk("wr data_format", 8'h31, 1, 48'h0B,   48'h0,    0, 1, 6'h31, 8'h0B);
        vecs[13] = mk("rd unmapped 05", 8'h85, 1, 48'h0,    48'h00,   1, 0, 6'h00, 8'h00);

        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        check("reset spi_sdo",    64'(spi_sdo),    64'h0);
        check("reset spi_sdo_oe", 64'(spi_sdo_oe), 64'h0);
        check("reset int1",       64'(int1),       64'h0);
        check("reset reg_wr_en",  64'(reg_wr_en),  64'h0);
        check("reset busy",       64'(busy),       64'h0);

        for (int i = 0; i < NV; i++) begin
            wr0 = wr_cnt;
            spi_xfer(vecs[i].cmd, vecs[i].nbytes, vecs[i].wdata, rd);
            if (vecs[i].chk_rd)
                check({vecs[i].name, " rd"}, 64'(rd), 64'(vecs[i].exp_rd));
            check({vecs[i].name, " wr count"}, 64'(wr_cnt - wr0), 64'(vecs[i].exp_wr));
            if (vecs[i].exp_wr > 0) begin
                check({vecs[i].name, " wr addr"}, 64'(last_addr), 64'(vecs[i].wr_addr));
                check({vecs[i].name, " wr data"}, 64'(last_data), 64'(vecs[i].wr_data));
            end
        end

        // Sample capture, DATA_READY interrupt, coherent burst and clear on data read.
        check("int1 before sample", 64'(int1), 64'h0);
        strobe_sample(16'h1234, 16'hFFEE, 16'h0100);
        @(negedge clk);
        check("int1 after sample", 64'(int1), 64'h1);
        spi_xfer(8'hB0, 1, 48'h0, rd);
        check("int_source ready", 64'(rd), 64'h80);
        check("int1 held over non-data read", 64'(int1), 64'h1);
        spi_xfer(8'hF2, 6, 48'h0, rd);
        check("xyz burst", 64'(rd), 64'h0100FFEE1234);
        repeat (3) @(negedge clk);
        check("int1 after data read", 64'(int1), 64'h0);
        spi_xfer(8'hB0, 1, 48'h0, rd);
        check("int_source cleared", 64'(rd), 64'h00);

        // Write aborted after 5 data bits: no pulse, register unchanged.
        wr0 = wr_cnt;
        spi_begin();
        spi_byte(8'h31, 8, b);
        spi_byte(8'hF0, 5, b);
        spi_end();
        check("abort wr count", 64'(wr_cnt - wr0), 64'h0);
        spi_xfer(8'hB1, 1, 48'h0, rd);
        check("abort data_format kept", 64'(rd), 64'h0B);

        // New sample in the same clk as the DATA_READY clear: set wins.
        strobe_sample(16'h00AB, 16'h0000, 16'h0000);
        spi_begin();
        spi_byte(8'hB2, 8, b);
        spi_byte(8'h00, 8, b);
        check("datax0 single read", 64'(b), 64'hAB);
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample_valid = 1'b1;
        @(negedge clk) sample_valid = 1'b0;
        repeat (HALF) @(negedge clk);
        check("set wins int1", 64'(int1), 64'h1);
        spi_xfer(8'hB0, 1, 48'h0, rd);
        check("set wins int_source", 64'(rd), 64'h80);

        // Reset mid-transaction: back to idle, remaining clocks ignored, no write.
        wr0 = wr_cnt;
        spi_begin();
        spi_byte(8'h2D, 8, b);
        check("oe during transfer", 64'(spi_sdo_oe), 64'h1);
        spi_byte(8'h5A, 4, b);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("oe after mid reset", 64'(spi_sdo_oe), 64'h0);
        spi_byte(8'hA5, 8, b);
        spi_byte(8'h3C, 8, b);
        check("busy while csn low", 64'(busy), 64'h1);
        check("oe ignored sclk", 64'(spi_sdo_oe), 64'h0);
        spi_end();
        check("mid reset wr count", 64'(wr_cnt - wr0), 64'h0);
        spi_xfer(8'hAD, 1, 48'h0, rd);
        check("power_ctl after reset", 64'(rd), 64'h00);
        spi_xfer(8'hAC, 1, 48'h0, rd);
        check("bw_rate after reset", 64'(rd), 64'h0A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
